// File: rtl/led_matrix_rx.sv
// HUB75 panel receiver: oversamples the panel lines, rebuilds each latched row pair and streams pixel words.
// Optional LED_RX_BLANK_CHECK_EN blanks the colour of rows that were never displayed (oeb low) since the previous latch.
module led_matrix_rx #(
    parameter int COLS        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        led_clk,
    input  logic        lat,
    input  logic        oeb,
    input  logic        r1,
    input  logic        g1,
    input  logic        b1,
    input  logic        r2,
    input  logic        g2,
    input  logic        b2,
    input  logic [2:0]  line,
    output logic [31:0] data_out,
    output logic        data_out_en,
    input  logic        data_out_rdy,
    output logic        frame_done,
    output logic        overrun
);
    localparam int          SW       = COLS * 3;
    localparam int          NIN      = 12;
    localparam logic [5:0]  LAST_IDX = 6'(2 * COLS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    logic [NIN-1:0]                  pin_s;
    logic [SYNC_STAGES-1:0][NIN-1:0] sync_r;
    logic [NIN-1:0]                  sy_s;
    logic [1:0]                      dly_r;
    logic                            shift_s;
    logic                            latch_s;
    logic                            oeb_sync_s;
    logic [2:0]                      rgb1_s;
    logic [2:0]                      rgb2_s;
    logic [2:0]                      line_sync_s;

    state_t          state_r, state_nxt_s;
    logic [5:0]      idx_r, idx_nxt_s;
    logic [5:0]      cnt_r, cnt_nxt_s;
    logic [SW-1:0]   upper_sr_r, lower_sr_r, upper_nxt_s, lower_nxt_s;
    logic [SW-1:0]   upper_hold_r, lower_hold_r;
    logic [2:0]      line_hold_r;
    logic            take_s;
    logic            accept_s;
    logic            en_r, en_nxt_s;
    logic [31:0]     dout_r, dout_nxt_s;
    logic            fd_r, fd_nxt_s;
    logic            ovr_r, ovr_nxt_s;
    logic            blank_r;
    logic            blank_new_s;

    function automatic logic [31:0] make_word(input logic [5:0] i, input logic [SW-1:0] up,
                                              input logic [SW-1:0] lo, input logic [2:0] ln,
                                              input logic blank);
        logic       half;
        logic [4:0] col;
        logic [2:0] pix;
        half = (i >= 6'(COLS));
        col  = half ? 5'(i - 6'(COLS)) : i[4:0];
        pix  = half ? lo[int'(col)*3 +: 3] : up[int'(col)*3 +: 3];
        pix  = blank ? 3'b000 : pix;
        return {7'd0, half, ln, col, 4'd0, {4{pix[2]}}, {4{pix[1]}}, {4{pix[0]}}};
    endfunction

    assign pin_s       = {led_clk, lat, oeb, r1, g1, b1, r2, g2, b2, line};
    assign sy_s        = sync_r[SYNC_STAGES-1];
    assign oeb_sync_s  = sy_s[9];
    assign rgb1_s      = sy_s[8:6];
    assign rgb2_s      = sy_s[5:3];
    assign line_sync_s = sy_s[2:0];
    assign shift_s     = sy_s[11] & ~dly_r[1];
    assign latch_s     = sy_s[10] & ~dly_r[0];
    assign accept_s    = en_r & data_out_rdy;

    // Synchroniser chain plus the edge-detect delay for led_clk and lat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
            dly_r  <= 2'b00;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pin_s};
            dly_r  <= sy_s[11:10];
        end
    end

    // Next shift-register contents; a shift coinciding with a latch lands in the latched row
    always_comb begin
        upper_nxt_s = upper_sr_r;
        lower_nxt_s = lower_sr_r;
        cnt_nxt_s   = cnt_r;
        if (shift_s) begin
            upper_nxt_s = {upper_sr_r[SW-4:0], rgb1_s};
            lower_nxt_s = {lower_sr_r[SW-4:0], rgb2_s};
            cnt_nxt_s   = (cnt_r == 6'd63) ? cnt_r : cnt_r + 6'd1;
        end else begin
            cnt_nxt_s   = cnt_r;
        end
    end

`ifdef LED_RX_BLANK_CHECK_EN
    logic seen_r;

    assign blank_new_s = take_s ? ~seen_r : blank_r;

    // Track whether the panel was enabled at least once between accepted latches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen_r  <= 1'b1;
            blank_r <= 1'b0;
        end else if (take_s) begin
            seen_r  <= ~oeb_sync_s;
            blank_r <= ~seen_r;
        end else if (!oeb_sync_s) begin
            seen_r  <= 1'b1;
        end
    end
`else
    logic unused_oeb_s;

    assign unused_oeb_s = oeb_sync_s;
    assign blank_r      = 1'b0;
    assign blank_new_s  = 1'b0;
`endif

    // Drain FSM: next state, word index and registered stream outputs
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        en_nxt_s    = en_r;
        dout_nxt_s  = dout_r;
        fd_nxt_s    = 1'b0;
        ovr_nxt_s   = ovr_r;
        take_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (latch_s) begin
                    take_s      = 1'b1;
                    state_nxt_s = ST_DRAIN;
                    idx_nxt_s   = 6'd0;
                    en_nxt_s    = 1'b1;
                    dout_nxt_s  = make_word(6'd0, upper_nxt_s, lower_nxt_s, line_sync_s, blank_new_s);
                    ovr_nxt_s   = ovr_r | (cnt_nxt_s != 6'(COLS));
                end else begin
                    en_nxt_s    = 1'b0;
                end
            end
            ST_DRAIN: begin
                ovr_nxt_s = ovr_r | latch_s;
                if (accept_s && idx_r == LAST_IDX) begin
                    state_nxt_s = ST_IDLE;
                    en_nxt_s    = 1'b0;
                    dout_nxt_s  = 32'd0;
                    fd_nxt_s    = (line_hold_r == 3'd7);
                end else if (accept_s) begin
                    idx_nxt_s   = idx_r + 6'd1;
                    dout_nxt_s  = make_word(idx_r + 6'd1, upper_hold_r, lower_hold_r, line_hold_r, blank_r);
                end else begin
                    idx_nxt_s   = idx_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                en_nxt_s    = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= 6'd0;
            cnt_r        <= 6'd0;
            upper_sr_r   <= '0;
            lower_sr_r   <= '0;
            upper_hold_r <= '0;
            lower_hold_r <= '0;
            line_hold_r  <= 3'd0;
            en_r         <= 1'b0;
            dout_r       <= 32'd0;
            fd_r         <= 1'b0;
            ovr_r        <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            cnt_r      <= take_s ? 6'd0 : cnt_nxt_s;
            upper_sr_r <= upper_nxt_s;
            lower_sr_r <= lower_nxt_s;
            en_r       <= en_nxt_s;
            dout_r     <= dout_nxt_s;
            fd_r       <= fd_nxt_s;
            ovr_r      <= ovr_nxt_s;
            if (take_s) begin
                upper_hold_r <= upper_nxt_s;
                lower_hold_r <= lower_nxt_s;
                line_hold_r  <= line_sync_s;
            end
        end
    end

    assign data_out    = dout_r;
    assign data_out_en = en_r;
    assign frame_done  = fd_r;
    assign overrun     = ovr_r;
endmodule

// File: tb/tb_led_matrix_rx.sv
// Directed self-checking bench for led_matrix_rx: shifts rows in over the panel lines and checks the word stream.
module tb_led_matrix_rx;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        led_clk = 1'b0;
    logic        lat = 1'b0;
    logic        oeb = 1'b1;
    logic        r1 = 1'b0, g1 = 1'b0, b1 = 1'b0;
    logic        r2 = 1'b0, g2 = 1'b0, b2 = 1'b0;
    logic [2:0]  line = 3'd0;
    logic        data_out_rdy = 1'b1;
    logic [31:0] data_out;
    logic        data_out_en;
    logic        frame_done;
    logic        overrun;

    int          checks = 0;
    int          failures = 0;
    int          rdy_mode = 0;
    int          cyc = 0;
    logic [31:0] words[$];
    int          acc_cyc[$];
    int          fd_count = 0;
    int          fd_size = 0;
    logic [31:0] fd_last = 32'd0;
    logic        stall_pending = 1'b0;
    logic [31:0] stall_word = 32'd0;

    led_matrix_rx #(.COLS(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .led_clk(led_clk), .lat(lat), .oeb(oeb),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2), .line(line),
        .data_out(data_out), .data_out_en(data_out_en), .data_out_rdy(data_out_rdy),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Ready pattern: always 1, or toggling every cycle
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1) data_out_rdy = ~data_out_rdy;
            else data_out_rdy = 1'b1;
        end
    end

    // Stream monitor on the falling edge: records accepted words, frame_done pulses and stall stability
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (stall_pending) begin
                    checks++;
                    if ({data_out_en, data_out} !== {1'b1, stall_word}) begin
                        failures++;
                        $display("FAIL stall_stable: en=%b data=%h, required en=1 data=%h", data_out_en, data_out, stall_word);
                    end
                end
                if (data_out_en && data_out_rdy) begin
                    words.push_back(data_out);
                    acc_cyc.push_back(cyc);
                end
                if (frame_done) begin
                    fd_count++;
                    fd_size = words.size();
                    fd_last = (words.size() > 0) ? words[words.size()-1] : 32'd0;
                end
                stall_pending = data_out_en && !data_out_rdy;
                stall_word    = data_out;
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_word(input int i, input logic [2:0] ln, input logic [2:0] rgb);
        logic [8:0]  adr;
        logic [11:0] colour;
        adr    = {(i >= 32) ? 1'b1 : 1'b0, ln, 5'(i % 32)};
        colour = {{4{rgb[2]}}, {4{rgb[1]}}, {4{rgb[0]}}};
        return {7'd0, adr, 4'd0, colour};
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        words.delete();
        acc_cyc.delete();
    endtask

    // pattern 0: constant u/l on every column; pattern 1: upper=col[2:0], lower=~col[2:0]
    task automatic load_row(input logic [2:0] ln, input int n, input int pattern,
                            input logic [2:0] u, input logic [2:0] l);
        @(posedge clk); #1 line = ln;
        for (int k = 0; k < n; k++) begin
            logic [4:0] col;
            col = 5'(31 - k);
            @(posedge clk); #1;
            if (pattern == 1) begin
                {r1, g1, b1} = col[2:0];
                {r2, g2, b2} = ~col[2:0];
            end else begin
                {r1, g1, b1} = u;
                {r2, g2, b2} = l;
            end
            @(posedge clk); #1 led_clk = 1'b1;
            repeat (3) @(posedge clk);
            #1 led_clk = 1'b0;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic pulse_lat();
        @(posedge clk); #1 lat = 1'b1;
        repeat (3) @(posedge clk);
        #1 lat = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int c = 0;
        while (words.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (words.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: got %0d words, required %0d", name, words.size(), n);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({data_out, data_out_en, frame_done, overrun} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: data=%h en=%b fd=%b ovr=%b, required all 0", data_out, data_out_en, frame_done, overrun);
        end
        reset = 1'b1;
        words.delete();
        acc_cyc.delete();
    endtask

    task automatic test_basic_row();
        rdy_mode = 0;
        load_row(3'd3, 32, 0, 3'b100, 3'b001);
        pulse_lat();
        wait_words(64, 300, "basic");
        repeat (20) @(posedge clk);
        checks++;
        if (words.size() != 64) begin
            failures++;
            $display("FAIL basic_count: got %0d words, required 64", words.size());
        end
        if (words.size() == 64) begin
            checks++;
            if (words[0] !== 32'h0060_0F00) begin
                failures++;
                $display("FAIL basic_word0: got %h, required 00600f00", words[0]);
            end
            checks++;
            if (words[32] !== 32'h0160_000F) begin
                failures++;
                $display("FAIL basic_word32: got %h, required 0160000f", words[32]);
            end
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (words[i] !== exp_word(i, 3'd3, (i < 32) ? 3'b100 : 3'b001)) begin
                    failures++;
                    $display("FAIL basic_word[%0d]: got %h, required %h", i, words[i], exp_word(i, 3'd3, (i < 32) ? 3'b100 : 3'b001));
                end
            end
            checks++;
            if (acc_cyc[63] - acc_cyc[0] != 63) begin
                failures++;
                $display("FAIL back_to_back: 64 words took %0d cycles, required 63", acc_cyc[63] - acc_cyc[0]);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL basic_overrun: got %b, required 0", overrun);
        end
    endtask

    task automatic test_stall();
        words.delete();
        acc_cyc.delete();
        rdy_mode = 1;
        load_row(3'd5, 32, 1, 3'b000, 3'b000);
        pulse_lat();
        wait_words(64, 500, "stall");
        repeat (20) @(posedge clk);
        checks++;
        if (words.size() != 64) begin
            failures++;
            $display("FAIL stall_count: got %0d words, required 64", words.size());
        end
        for (int i = 0; i < 64 && i < words.size(); i++) begin
            logic [4:0] col;
            col = 5'(i % 32);
            checks++;
            if (words[i] !== exp_word(i, 3'd5, (i < 32) ? col[2:0] : ~col[2:0])) begin
                failures++;
                $display("FAIL stall_word[%0d]: got %h, required %h", i, words[i], exp_word(i, 3'd5, (i < 32) ? col[2:0] : ~col[2:0]));
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_short_row();
        words.delete();
        acc_cyc.delete();
        load_row(3'd1, 31, 0, 3'b010, 3'b010);
        pulse_lat();
        wait_words(64, 300, "short");
        repeat (50) @(posedge clk);
        checks++;
        if (words.size() != 64) begin
            failures++;
            $display("FAIL short_count: got %0d words, required 64", words.size());
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL short_overrun: got %b, required 1", overrun);
        end
    endtask

    task automatic test_latch_in_drain();
        apply_reset();
        #1;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_cleared: got %b after reset, required 0", overrun);
        end
        rdy_mode = 1;
        load_row(3'd2, 32, 0, 3'b111, 3'b000);
        pulse_lat();
        wait_words(10, 300, "drain_w10");
        pulse_lat();
        wait_words(64, 500, "drain_full");
        repeat (100) @(posedge clk);
        checks++;
        if (words.size() != 64) begin
            failures++;
            $display("FAIL drain_latch_count: got %0d words, required 64", words.size());
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL drain_latch_overrun: got %b, required 1", overrun);
        end
        rdy_mode = 0;
    endtask

    task automatic test_frame();
        apply_reset();
        fd_count = 0;
        for (int ln = 0; ln < 8; ln++) begin
            load_row(3'(ln), 32, 0, 3'b111, 3'b111);
            pulse_lat();
            wait_words(64 * (ln + 1), 300, "frame");
        end
        repeat (20) @(posedge clk);
        checks++;
        if (words.size() != 512) begin
            failures++;
            $display("FAIL frame_count: got %0d words, required 512", words.size());
        end
        for (int i = 0; i < 512 && i < words.size(); i++) begin
            checks++;
            if (words[i] !== exp_word(i % 64, 3'(i / 64), 3'b111)) begin
                failures++;
                $display("FAIL frame_word[%0d]: got %h, required %h", i, words[i], exp_word(i % 64, 3'(i / 64), 3'b111));
            end
        end
        checks++;
        if (fd_count != 1) begin
            failures++;
            $display("FAIL frame_done_count: got %0d pulses, required 1", fd_count);
        end
        checks++;
        if (fd_size != 512 || fd_last[24:16] !== 9'h1FF) begin
            failures++;
            $display("FAIL frame_done_timing: words=%0d last adr=%h, required 512 and 1ff", fd_size, fd_last[24:16]);
        end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        load_row(3'd6, 32, 0, 3'b101, 3'b011);
        pulse_lat();
        wait_words(20, 300, "mid_w20");
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({data_out, data_out_en} !== 33'd0) begin
            failures++;
            $display("FAIL reset_async: data=%h en=%b, required 0", data_out, data_out_en);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        words.delete();
        acc_cyc.delete();
        repeat (20) @(posedge clk);
        checks++;
        if (words.size() != 0) begin
            failures++;
            $display("FAIL reset_discard: got %0d words after reset, required 0", words.size());
        end
        load_row(3'd2, 32, 0, 3'b010, 3'b100);
        pulse_lat();
        wait_words(64, 300, "after_reset");
        repeat (20) @(posedge clk);
        checks++;
        if (words.size() != 64) begin
            failures++;
            $display("FAIL after_reset_count: got %0d words, required 64", words.size());
        end
        if (words.size() == 64) begin
            checks++;
            if (words[0] !== 32'h0040_00F0) begin
                failures++;
                $display("FAIL after_reset_word0: got %h, required 004000f0", words[0]);
            end
            checks++;
            if (words[32] !== 32'h0140_0F00) begin
                failures++;
                $display("FAIL after_reset_word32: got %h, required 01400f00", words[32]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_stall();
        test_short_row();
        test_latch_in_drain();
        test_frame();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
